// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: buffers fetched {pc, instruction, compressed} entries
// between fetch and decode, drops bubbles, and discards everything on flush.
// Optional performance counters are compiled in with `define IFID_PERF_EN.
module if_id_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_ins,
    input  logic                     if_comp,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_ins,
    output logic                     id_comp,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] pc_d  [DEPTH];
    logic [XLEN-1:0] ins_q [DEPTH];
    logic [XLEN-1:0] ins_d [DEPTH];
    logic            comp_q [DEPTH];
    logic            comp_d [DEPTH];

    logic push;
    logic pop;
    logic store;

    // Handshakes; if_ready depends only on reset and stored count
    assign if_ready = !Rst && (count_q < FULL);
    assign id_valid = (count_q != '0);
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;
    assign store    = push && !flush && (if_ins != '0);

    // Head entry toward decode, forced to zero when empty
    assign id_pc     = id_valid ? pc_q[rd_ptr_q]   : '0;
    assign id_ins    = id_valid ? ins_q[rd_ptr_q]  : '0;
    assign id_comp   = id_valid ? comp_q[rd_ptr_q] : 1'b0;
    assign occupancy = count_q;

    // Next-state for pointers, count and storage; flush wins over push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        comp_d   = comp_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (store) begin
                pc_d[wr_ptr_q]   = if_pc;
                ins_d[wr_ptr_q]  = if_ins;
                comp_d[wr_ptr_q] = if_comp;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '{default: '0};
            ins_q    <= '{default: '0};
            comp_q   <= '{default: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            comp_q   <= comp_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating stall and useful-flush counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (if_valid && !if_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (count_q != '0) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: per-scenario tasks plus a scoreboard monitor that
// records expected entries on accepted pushes and checks them on pops.
module tb_if_id_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        comp;
    } ent_t;

    logic        clk = 1'b0;
    logic        Rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_comp;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    logic        id_comp;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;
    ent_t sb[$];

`ifdef IFID_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    if_id_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_ins    (if_ins),
        .if_comp   (if_comp),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_ins    (id_ins),
        .id_comp   (id_comp),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: inputs are stable at the falling edge
    always @(negedge clk) begin
        ent_t e;
        if (Rst || flush) begin
            sb.delete();
        end else begin
            if (id_valid && id_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_pop: id_pc=%h popped but no entry expected", id_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if ({id_pc, id_ins, id_comp} !== {e.pc, e.ins, e.comp}) begin
                        fails++;
                        $display("FAIL sb_pop: got pc=%h ins=%h comp=%b expected pc=%h ins=%h comp=%b",
                                 id_pc, id_ins, id_comp, e.pc, e.ins, e.comp);
                    end
                end
            end
            if (if_valid && if_ready && (if_ins != 32'd0)) begin
                e.pc   = if_pc;
                e.ins  = if_ins;
                e.comp = if_comp;
                sb.push_back(e);
            end
        end
    end

    // Watchdog against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; flush = 1'b0; if_valid = 1'b1; if_pc = 32'h500;
        if_ins = 32'h13; if_comp = 1'b0; id_ready = 1'b0;
        cyc(); cyc();
        tests++;
        if ({if_ready, id_valid, id_pc, id_ins, id_comp, occupancy} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset_state: if_ready=%b id_valid=%b id_pc=%h id_ins=%h comp=%b occ=%0d expected all zero",
                     if_ready, id_valid, id_pc, id_ins, id_comp, occupancy);
        end
        tests++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            fails++;
            $display("FAIL reset_counters: stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
        end
        Rst = 1'b0; if_valid = 1'b0;
        #1;
        tests++;
        if (if_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: if_ready=%b expected 1", if_ready);
        end
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'h100; if_ins = 32'h00A00093; if_comp = 1'b0;
        cyc();
        if_valid = 1'b0;
        tests++;
        if ({id_valid, id_pc, id_ins, id_comp, occupancy} !== {1'b1, 32'h100, 32'h00A00093, 1'b0, 2'd1}) begin
            fails++;
            $display("FAIL single_head: valid=%b pc=%h ins=%h comp=%b occ=%0d expected 1 100 00a00093 0 1",
                     id_valid, id_pc, id_ins, id_comp, occupancy);
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        tests++;
        if ({id_valid, occupancy} !== {1'b0, 2'd0}) begin
            fails++;
            $display("FAIL single_pop: valid=%b occ=%0d expected 0 0", id_valid, occupancy);
        end
    endtask

    task automatic test_full();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0; if_ins = 32'h00004501; if_comp = 1'b1;
        cyc();
        if_pc = 32'h2; if_ins = 32'h00000013; if_comp = 1'b0;
        cyc();
        tests++;
        if ({occupancy, if_ready} !== {2'd2, 1'b0}) begin
            fails++;
            $display("FAIL full_state: occ=%0d if_ready=%b expected 2 0", occupancy, if_ready);
        end
        if_pc = 32'h6; if_ins = 32'h00200093;
        cyc();
        tests++;
        if ({occupancy, id_pc, id_comp} !== {2'd2, 32'h0, 1'b1}) begin
            fails++;
            $display("FAIL full_reject: occ=%0d head=%h comp=%b expected 2 0 1", occupancy, id_pc, id_comp);
        end
        id_ready = 1'b1;
        cyc();
        tests++;
        if ({if_ready, occupancy, id_pc} !== {1'b1, 2'd1, 32'h2}) begin
            fails++;
            $display("FAIL full_pop1: if_ready=%b occ=%0d head=%h expected 1 1 2", if_ready, occupancy, id_pc);
        end
        cyc();
        if_valid = 1'b0;
        tests++;
        if ({occupancy, id_pc, id_ins} !== {2'd1, 32'h6, 32'h00200093}) begin
            fails++;
            $display("FAIL full_pop2: occ=%0d head=%h ins=%h expected 1 6 00200093", occupancy, id_pc, id_ins);
        end
        cyc();
        id_ready = 1'b0;
        tests++;
        if ({occupancy, id_valid} !== {2'd0, 1'b0}) begin
            fails++;
            $display("FAIL full_drain: occ=%0d valid=%b expected 0 0", occupancy, id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h20; if_ins = 32'h13; if_comp = 1'b0;
        cyc();
        if_pc = 32'h24;
        cyc();
        flush = 1'b1; if_pc = 32'h40;
        cyc();
        flush = 1'b0; if_valid = 1'b0;
        tests++;
        if ({id_valid, occupancy, flush_cnt} !== {1'b0, 2'd0, (PERF ? 32'd1 : 32'd0)}) begin
            fails++;
            $display("FAIL flush_full: valid=%b occ=%0d flush_cnt=%0d expected 0 0 %0d",
                     id_valid, occupancy, flush_cnt, PERF ? 1 : 0);
        end
        cyc();
        tests++;
        if ({id_valid, id_pc} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL flush_no_40: valid=%b pc=%h expected 0 0", id_valid, id_pc);
        end
        if_valid = 1'b1; if_pc = 32'h48;
        cyc();
        flush = 1'b1; if_pc = 32'h44;
        #1;
        tests++;
        if (if_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_push_ready: if_ready=%b expected 1", if_ready);
        end
        cyc();
        flush = 1'b0; if_valid = 1'b0;
        cyc();
        tests++;
        if ({occupancy, flush_cnt} !== {2'd0, (PERF ? 32'd2 : 32'd0)}) begin
            fails++;
            $display("FAIL flush_drop_push: occ=%0d flush_cnt=%0d expected 0 %0d", occupancy, flush_cnt, PERF ? 2 : 0);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        tests++;
        if (flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin
            fails++;
            $display("FAIL flush_empty: flush_cnt=%0d expected %0d", flush_cnt, PERF ? 2 : 0);
        end
    endtask

    task automatic test_bubble();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h60; if_ins = 32'h0; if_comp = 1'b0;
        cyc();
        tests++;
        if ({occupancy, id_valid} !== {2'd0, 1'b0}) begin
            fails++;
            $display("FAIL bubble_empty: occ=%0d valid=%b expected 0 0", occupancy, id_valid);
        end
        if_pc = 32'h64; if_ins = 32'h13;
        cyc();
        if_pc = 32'h68; if_ins = 32'h0;
        cyc();
        if_valid = 1'b0;
        tests++;
        if ({occupancy, id_pc} !== {2'd1, 32'h64}) begin
            fails++;
            $display("FAIL bubble_one: occ=%0d head=%h expected 1 64", occupancy, id_pc);
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = pops;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1; if_pc = 32'(i * 4); if_ins = 32'h13 | 32'(i << 7); if_comp = 1'b0;
            cyc();
            tests++;
            if ({id_valid, id_pc, occupancy} !== {1'b1, 32'(i * 4), 2'd1}) begin
                fails++;
                $display("FAIL stream_%0d: valid=%b pc=%h occ=%0d expected 1 %h 1",
                         i, id_valid, id_pc, occupancy, i * 4);
            end
        end
        if_valid = 1'b0;
        cyc();
        id_ready = 1'b0;
        tests++;
        if ({occupancy, 32'(pops - start_pops)} !== {2'd0, 32'd8}) begin
            fails++;
            $display("FAIL stream_total: occ=%0d popped=%0d expected 0 8", occupancy, pops - start_pops);
        end
    endtask

    task automatic test_perf();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h70; if_ins = 32'h13; if_comp = 1'b0;
        cyc();
        if_valid = 1'b0;
        #2 Rst = 1'b1;
        #1;
        tests++;
        if ({occupancy, id_valid, if_ready, id_pc} !== {2'd0, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL async_reset: occ=%0d valid=%b if_ready=%b pc=%h expected 0 0 0 0",
                     occupancy, id_valid, if_ready, id_pc);
        end
        cyc();
        Rst = 1'b0;
        if_valid = 1'b1; if_pc = 32'h80;
        cyc();
        if_pc = 32'h84;
        cyc();
        if_pc = 32'h88;
        repeat (5) cyc();
        if_valid = 1'b0;
        tests++;
        if ({stall_cnt, occupancy} !== {(PERF ? 32'd5 : 32'd0), 2'd2}) begin
            fails++;
            $display("FAIL perf_stall: stall_cnt=%0d occ=%0d expected %0d 2", stall_cnt, occupancy, PERF ? 5 : 0);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        tests++;
        if ({flush_cnt, occupancy} !== {(PERF ? 32'd1 : 32'd0), 2'd0}) begin
            fails++;
            $display("FAIL perf_flush: flush_cnt=%0d occ=%0d expected %0d 0", flush_cnt, occupancy, PERF ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_bubble();
        test_back_to_back();
        test_perf();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
